bram_sdp_be: RTL and testbench
==============================

# bram_sdp_be

Parametrised simple-dual-port block RAM model with byte-lane write enables, the next generation of the team's fixed 11-word tap/data RAMs. It gives one write port and one read port sharing a clock, plus the following:
- configurable width and depth;
- optional output register;
- selectable read-during-write behaviour;
- a post-reset zero-fill sequencer;
- sticky out-of-range error reporting.

It sits behind the FIR/AXI-Lite controllers as coefficient and data-history storage. It is a simulation model, not a synthesis target.

## Interface
- DW, 32, data width in bits; multiple of 8.
- DEPTH, 11, number of words.
- AW, 12, byte-address width.
- OUT_REG, 0, 0 gives read latency 1; 1 adds an output register stage for latency 2.
- RDW_MODE, 0, same-word read-during-write: 0 = read-first (old data), 1 = write-first (new merged data).
- CLK  in  1  single clock; all state changes on its rising edge.
- RST  in  1  reset, asynchronous, active-high.
- EN_W  in  1  write-port enable.
- WE  in  DW/8  byte-lane write enables; lane i covers Di[8i+7:8i].
- A_W  in  AW  write byte address.
- Di  in  DW  write data.
- EN_R  in  1  read-port enable.
- A_R  in  AW  read byte address.
- Do  out  DW  read data; registered and held until the next valid read.
- Do_valid  out  1  one-cycle pulse marking new Do.
- ready  out  1  high once zero-fill has completed.
- oor_err  out  1  sticky out-of-range flag.

## Operation
- Word index = byte address >> log2(DW/8); the low address bits are ignored.
- Address is in range iff word index < DEPTH.
- FSM states:
  - INIT: entered on RST. A counter walks 0..DEPTH-1 and writes 0 to one word per cycle. ready=0.
  - RUN: entered after word DEPTH-1 is written. ready=1. Stays in RUN until RST.
- While in INIT, EN_W and EN_R are ignored, Do_valid stays 0, and oor_err is not updated.
- Write in RUN: when EN_W=1, address is in range and WE≠0, update only the enabled lanes; other lanes keep their value. EN_W=1 with WE=0 is a no-op.
- Read in RUN: EN_R=1 launches a read. Result pipeline:
  - stage 1 captures the word, or 0 if the address is out of range;
  - with OUT_REG=1 a second stage follows;
  - the final stage loads Do and pulses Do_valid.
- Do is not masked by EN_R; it holds its last value.
- Collision (EN_W and EN_R in the same cycle, same in-range word index):
  - RDW_MODE=0 returns the pre-write word;
  - RDW_MODE=1 returns the word with enabled Di lanes merged in.
- The write always takes effect.
- Out of range: when EN_W=1 or EN_R=1 with an out-of-range index in RUN, set oor_err. The write is dropped; the read returns 0 with Do_valid=1. oor_err clears only on RST.
- RST mid-operation:
  - the pipeline flushes and no pending Do_valid is emitted;
  - the FSM restarts INIT from word 0;
  - memory is re-zeroed.

## Timing
- Reset values: Do=0, Do_valid=0, ready=0, oor_err=0, FSM=INIT, fill counter=0.
- These take effect immediately on RST assertion, with no clock needed.
- Zero-fill takes DEPTH cycles. With RST deasserted before edge 0, ready rises after edge DEPTH-1. The first accepted access is on edge DEPTH.
- Read latency counts from the edge that samples EN_R:
  - OUT_REG=0: Do and Do_valid update on edge +1;
  - OUT_REG=1: they update on edge +2.
- Back-to-back reads give one result per cycle at full throughput.
- A written value is visible to a read launched on the following edge, in either mode.
- oor_err rises on the edge after the offending access.

## Test plan
- Reset/init, DEPTH=11: assert RST, release; ready=0 for 11 cycles, then 1. Reading every word in order gives Do=0x00000000 and 11 Do_valid pulses.
- Byte lanes: write 0xAABBCCDD with WE=4'hF to A_W=0x8, then Di=0x11223344 with WE=4'b0101. Read 0x8 gives 0xAA22CC44. A write with WE=0 leaves the word unchanged.
- Collision: word 3 holds 0x1; same cycle EN_W, Di=0x5A5A5A5A, WE=F, EN_R, A=0xC. RDW_MODE=0 gives Do=0x00000001; RDW_MODE=1 gives 0x5A5A5A5A. A following read gives 0x5A5A5A5A in both modes.
- Latency: OUT_REG=0 and OUT_REG=1, reads of 0x0, 0x4, 0x8 on consecutive cycles. Do_valid is high for 3 consecutive cycles starting at +1 and +2 respectively, with the data in order.
- Out of range: write to A_W=0x2C (word 11) sets oor_err the next cycle, and word 0 stays unchanged. Read 0x30 gives Do=0 with Do_valid=1. oor_err stays 1 until RST.
- Reset mid-read: with OUT_REG=1, assert RST one cycle after EN_R. No Do_valid appears, Do=0 immediately, and INIT restarts with ready=0 for 11 cycles.

Source files
------------

// File: rtl/bram_sdp_be.sv
// rtl/bram_sdp_be.sv - simple-dual-port byte-lane RAM model with zero-fill sequencer and sticky range error
module bram_sdp_be #(
  parameter int DW       = 32,
  parameter int DEPTH    = 11,
  parameter int AW       = 12,
  parameter int OUT_REG  = 0,
  parameter int RDW_MODE = 0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EN_W,
  input  logic [DW/8-1:0] WE,
  input  logic [AW-1:0]   A_W,
  input  logic [DW-1:0]   Di,
  input  logic            EN_R,
  input  logic [AW-1:0]   A_R,
  output logic [DW-1:0]   Do,
  output logic            Do_valid,
  output logic            ready,
  output logic            oor_err
);
  localparam int NB  = DW / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW  = AW - LSB;
  localparam int MW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t        state_q, state_d;
  logic [MW-1:0] fill_cnt;
  logic [DW-1:0] mem [DEPTH];

  logic [IW-1:0] w_idx, r_idx;
  logic          w_in, r_in;
  logic          wr_fire, rd_fire, collide, oor_hit;
  logic [DW-1:0] wr_mask, rd_word, rd_merged, rd_result;
  logic          s1_valid, fin_valid;
  logic [DW-1:0] s1_data, fin_data;

  // Word indices drop the byte-offset bits; range check is against DEPTH words
  assign w_idx   = IW'(A_W >> LSB);
  assign r_idx   = IW'(A_R >> LSB);
  assign w_in    = (w_idx < IW'(DEPTH));
  assign r_in    = (r_idx < IW'(DEPTH));
  assign ready   = (state_q == RUN);
  assign wr_fire = ready && EN_W && w_in && (WE != '0);
  assign rd_fire = ready && EN_R;
  assign collide = wr_fire && r_in && (r_idx == w_idx);

  // Expand byte enables to a bit mask and build the read result, including the write-first bypass
  always_comb begin
    wr_mask   = '0;
    rd_word   = '0;
    rd_result = '0;
    for (int i = 0; i < NB; i++) begin
      wr_mask[8*i +: 8] = {8{WE[i]}};
    end
    if (r_in) begin
      rd_word = mem[r_idx[MW-1:0]];
    end
    rd_merged = (rd_word & ~wr_mask) | (Di & wr_mask);
    if (!r_in) begin
      rd_result = '0;
    end else if ((RDW_MODE != 0) && collide) begin
      rd_result = rd_merged;
    end else begin
      rd_result = rd_word;
    end
  end

  // Fill sequencer state and word counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= INIT;
      fill_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT && fill_cnt != MW'(DEPTH - 1)) begin
        fill_cnt <= fill_cnt + MW'(1);
      end
    end
  end

  // Leave INIT once the last word has been zeroed; RUN holds until reset
  always_comb begin
    state_d = state_q;
    if (state_q == INIT && fill_cnt == MW'(DEPTH - 1)) begin
      state_d = RUN;
    end
  end

  // Storage: zero one word per cycle during INIT, merge enabled lanes in RUN
  always_ff @(posedge CLK) begin
    if (state_q == INIT) begin
      mem[fill_cnt] <= '0;
    end else if (wr_fire) begin
      mem[w_idx[MW-1:0]] <= (mem[w_idx[MW-1:0]] & ~wr_mask) | (Di & wr_mask);
    end
  end

  // Out-of-range detection is registered once, then folded into the sticky flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      oor_hit <= 1'b0;
      oor_err <= 1'b0;
    end else begin
      oor_hit <= ready && ((EN_W && !w_in) || (EN_R && !r_in));
      if (oor_hit) begin
        oor_err <= 1'b1;
      end
    end
  end

  // Stage 1 captures the addressed word (0 when out of range) on the sampling edge
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_fire;
      if (rd_fire) begin
        s1_data <= rd_result;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic          s2_valid;
      logic [DW-1:0] s2_data;
      // Optional extra pipeline stage between capture and output
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_data <= s1_data;
          end
        end
      end
      assign fin_valid = s2_valid;
      assign fin_data  = s2_data;
    end else begin : g_direct
      assign fin_valid = s1_valid;
      assign fin_data  = s1_data;
    end
  endgenerate

  // Output stage: Do holds between results, Do_valid pulses for each new one
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Do       <= '0;
      Do_valid <= 1'b0;
    end else begin
      Do_valid <= fin_valid;
      if (fin_valid) begin
        Do <= fin_data;
      end
    end
  end

endmodule

// File: tb/tb_bram_sdp_be.sv
// tb/tb_bram_sdp_be.sv - randomized self-checking bench for bram_sdp_be against a word-array reference model
module tb_bram_sdp_be;
  localparam int DEPTH = 11;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN_W = 1'b0, EN_R = 1'b0;
  logic [3:0]  WE = '0;
  logic [11:0] A_W = '0, A_R = '0;
  logic [31:0] Di = '0;
  logic [31:0] do0, do1;
  logic        dv0, dv1, rdy0, rdy1, oor0, oor1;

  always #5 CLK = ~CLK;

  bram_sdp_be #(.DW(32), .DEPTH(DEPTH), .AW(12), .OUT_REG(0), .RDW_MODE(0)) u0 (
    .CLK(CLK), .RST(RST), .EN_W(EN_W), .WE(WE), .A_W(A_W), .Di(Di),
    .EN_R(EN_R), .A_R(A_R), .Do(do0), .Do_valid(dv0), .ready(rdy0), .oor_err(oor0));

  bram_sdp_be #(.DW(32), .DEPTH(DEPTH), .AW(12), .OUT_REG(1), .RDW_MODE(1)) u1 (
    .CLK(CLK), .RST(RST), .EN_W(EN_W), .WE(WE), .A_W(A_W), .Di(Di),
    .EN_R(EN_R), .A_R(A_R), .Do(do1), .Do_valid(dv1), .ready(rdy1), .oor_err(oor1));

  typedef struct packed {
    int          due;
    logic [31:0] data;
  } rd_t;

  int          n_cmp = 0, n_bad = 0;
  int          edge_n = 0, since_rst = 0, oor_due = -1;
  int          pulses0 = 0, pulses1 = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last0 = '0, last1 = '0;
  logic [31:0] saved;
  rd_t         q0[$], q1[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // Reference: what the upcoming edge does, stated in terms of whole words and lanes
  task automatic model_edge();
    int          wi, ri;
    logic [31:0] nw, old;
    if (since_rst < DEPTH) return;
    wi = int'(A_W) / 4;
    ri = int'(A_R) / 4;
    nw = (wi < DEPTH) ? ref_mem[wi] : 32'h0;
    for (int b = 0; b < 4; b++) if (WE[b]) nw[8*b +: 8] = Di[8*b +: 8];
    if (EN_R) begin
      old = (ri < DEPTH) ? ref_mem[ri] : 32'h0;
      q0.push_back('{due: edge_n + 2, data: old});
      q1.push_back('{due: edge_n + 3, data: (EN_W && ri == wi && ri < DEPTH) ? nw : old});
    end
    if (((EN_W && wi >= DEPTH) || (EN_R && ri >= DEPTH)) && oor_due < 0) oor_due = edge_n + 2;
    if (EN_W && wi < DEPTH) ref_mem[wi] = nw;
  endtask

  task automatic check_outputs();
    check("ready0", 32'(rdy0), 32'(since_rst >= DEPTH));
    check("ready1", 32'(rdy1), 32'(since_rst >= DEPTH));
    if (dv0) pulses0++;
    if (dv1) pulses1++;
    if (q0.size() > 0 && q0[0].due == edge_n) begin
      check("dv0", 32'(dv0), 32'd1);
      last0 = q0[0].data;
      void'(q0.pop_front());
    end else check("dv0", 32'(dv0), 32'd0);
    if (q1.size() > 0 && q1[0].due == edge_n) begin
      check("dv1", 32'(dv1), 32'd1);
      last1 = q1[0].data;
      void'(q1.pop_front());
    end else check("dv1", 32'(dv1), 32'd0);
    check("do0", do0, last0);
    check("do1", do1, last1);
    check("oor0", 32'(oor0), 32'(oor_due >= 0 && edge_n >= oor_due));
    check("oor1", 32'(oor1), 32'(oor_due >= 0 && edge_n >= oor_due));
  endtask

  task automatic step();
    model_edge();
    @(posedge CLK);
    edge_n++;
    since_rst++;
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic idle();
    EN_W = 1'b0; EN_R = 1'b0; WE = '0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    check("rst_do0", do0, 32'h0);
    check("rst_do1", do1, 32'h0);
    check("rst_dv", 32'({dv1, dv0}), 32'h0);
    check("rst_ready", 32'({rdy1, rdy0}), 32'h0);
    check("rst_oor", 32'({oor1, oor0}), 32'h0);
    q0.delete(); q1.delete();
    last0 = '0; last1 = '0; oor_due = -1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    since_rst = 0;
  endtask

  task automatic rand_inputs(input bit allow_oor);
    int hi;
    hi   = allow_oor ? 4 * DEPTH + 15 : 4 * DEPTH - 1;
    EN_W = 1'($urandom_range(0, 1));
    EN_R = 1'($urandom_range(0, 1));
    WE   = 4'($urandom);
    Di   = $urandom;
    A_W  = 12'($urandom_range(0, hi));
    A_R  = ($urandom_range(0, 3) == 0) ? A_W : 12'($urandom_range(0, hi));
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] we);
    EN_W = 1'b1; EN_R = 1'b0; A_W = a; Di = d; WE = we;
    step();
  endtask

  task automatic rd(input logic [11:0] a);
    EN_W = 1'b0; EN_R = 1'b1; A_R = a; WE = '0;
    step();
  endtask

  initial begin
    @(negedge CLK);
    do_reset();

    // Fill phase: random traffic (including out-of-range) must be ignored
    for (int i = 0; i < DEPTH; i++) begin
      rand_inputs(1'b1);
      step();
    end
    idle();

    // Every word reads back as zero, one pulse per read
    pulses0 = 0; pulses1 = 0;
    for (int i = 0; i < DEPTH; i++) rd(12'(4 * i));
    idle(); step(); step();
    check("fill_pulses0", 32'(pulses0), 32'd11);
    check("fill_pulses1", 32'(pulses1), 32'd11);

    // Byte lanes
    wr(12'h008, 32'hAABBCCDD, 4'hF);
    wr(12'h008, 32'h11223344, 4'b0101);
    wr(12'h008, 32'hFFFFFFFF, 4'h0);
    rd(12'h008);
    idle(); step(); step();
    check("lanes_do0", do0, 32'hAA22CC44);
    check("lanes_do1", do1, 32'hAA22CC44);

    // Collision on word 3
    wr(12'h00C, 32'h00000001, 4'hF);
    EN_W = 1'b1; EN_R = 1'b1; A_W = 12'h00C; A_R = 12'h00C; Di = 32'h5A5A5A5A; WE = 4'hF;
    step();
    rd(12'h00C);
    check("coll_rf", do0, 32'h00000001);
    idle(); step();
    check("coll_wf", do1, 32'h5A5A5A5A);
    check("coll_next0", do0, 32'h5A5A5A5A);
    step();
    check("coll_next1", do1, 32'h5A5A5A5A);

    // Back-to-back reads
    rd(12'h000); rd(12'h004); rd(12'h008);
    idle(); step(); step(); step();

    // Random traffic, in range only
    for (int i = 0; i < 300; i++) begin
      rand_inputs(1'b0);
      step();
    end
    idle(); step(); step();

    // Out of range write, then read
    saved = ref_mem[0];
    wr(12'h02C, 32'hCAFEF00D, 4'hF);
    idle(); check("oor_before", 32'(oor0), 32'd0);
    step();
    check("oor_after", 32'(oor0), 32'd1);
    rd(12'h030);
    idle(); step(); step();
    check("oor_rd0", do0, 32'h0);
    check("oor_rd1", do1, 32'h0);
    rd(12'h000);
    idle(); step(); step();
    check("oor_word0", do1, saved);

    // Random traffic including out-of-range addresses
    for (int i = 0; i < 200; i++) begin
      rand_inputs(1'b1);
      step();
    end
    idle(); step(); step();

    // Reset one cycle after a read launch: nothing may emerge afterwards
    wr(12'h008, 32'hDEADBEEF, 4'hF);
    rd(12'h008);
    idle();
    do_reset();
    for (int i = 0; i < DEPTH + 3; i++) step();
    rd(12'h008);
    idle(); step(); step();
    check("rezero", do1, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
